// File: rtl/decode_out_queue_pkg.sv
// Shared types and sizing for the decode-to-execute bundle queue.
// The bundle struct is laid out MSB-first as IR, npc, E, M, W, matching the RAM word.
package decode_out_queue_pkg;

  localparam int DEF_IR_W  = 16;
  localparam int DEF_NPC_W = 16;
  localparam int DEF_E_W   = 6;
  localparam int DEF_M_W   = 1;
  localparam int DEF_W_W   = 2;
  localparam int DEF_DEPTH = 2;

  localparam int PTR_W = $clog2(DEF_DEPTH);
  localparam int CNT_W = $clog2(DEF_DEPTH + 1);

  typedef struct packed {
    logic [DEF_IR_W-1:0]  ir;
    logic [DEF_NPC_W-1:0] npc;
    logic [DEF_E_W-1:0]   e_control;
    logic [DEF_M_W-1:0]   m_control;
    logic [DEF_W_W-1:0]   w_control;
  } decode_bundle_t;

  function automatic int bundle_width(input int ir_w, input int npc_w,
                                      input int e_w, input int m_w, input int w_w);
    return ir_w + npc_w + e_w + m_w + w_w;
  endfunction

endpackage

// File: rtl/decode_out_queue_if.sv
// Decode/execute handshake and payload bundle of the output queue.
// master = decode+execute side driving the queue, slave = the queue itself.
interface decode_out_queue_if #(
  parameter int IR_W  = 16,
  parameter int NPC_W = 16,
  parameter int E_W   = 6,
  parameter int M_W   = 1,
  parameter int W_W   = 2,
  parameter int DEPTH = 2
);
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic                       enable_decode;
  logic [IR_W-1:0]            IR_in;
  logic [NPC_W-1:0]           npc_in;
  logic [E_W-1:0]             E_control_in;
  logic [M_W-1:0]             M_control_in;
  logic [W_W-1:0]             W_control_in;
  logic                       out_valid;
  logic                       out_ready;
  logic [IR_W-1:0]            IR;
  logic [NPC_W-1:0]           npc_out;
  logic [E_W-1:0]             E_control;
  logic [M_W-1:0]             M_control;
  logic [W_W-1:0]             W_control;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output flush, in_valid, IR_in, npc_in, E_control_in, M_control_in, W_control_in, out_ready,
    input  in_ready, enable_decode, out_valid, IR, npc_out, E_control, M_control, W_control, count
  );

  modport slave (
    input  flush, in_valid, IR_in, npc_in, E_control_in, M_control_in, W_control_in, out_ready,
    output in_ready, enable_decode, out_valid, IR, npc_out, E_control, M_control, W_control, count
  );
endinterface

// File: rtl/decode_out_entry_ram.sv
// DEPTH x WIDTH register array: one-hot write enable, asynchronous read.
module decode_out_entry_ram #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 41
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DEPTH-1:0]           wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // NOTE: start from the held value so unwritten entries never imply a latch.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_d[i] = wr_data;
    end
  end

  // NOTE: storage is cleared on reset so a stale bundle can never reappear after restart.
  always_ff @(posedge clock) begin
    if (reset) mem_q <= '{default: '0};
    else       mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/decode_out_queue.sv
// DEPTH-entry FIFO between decode and execute with valid/ready on both sides,
// flush, and the legacy enable_decode back-pressure output.
module decode_out_queue #(
  parameter int IR_W  = 16,
  parameter int NPC_W = 16,
  parameter int E_W   = 6,
  parameter int M_W   = 1,
  parameter int W_W   = 2,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       enable_decode,
  input  logic [IR_W-1:0]            IR_in,
  input  logic [NPC_W-1:0]           npc_in,
  input  logic [E_W-1:0]             E_control_in,
  input  logic [M_W-1:0]             M_control_in,
  input  logic [W_W-1:0]             W_control_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IR_W-1:0]            IR,
  output logic [NPC_W-1:0]           npc_out,
  output logic [E_W-1:0]             E_control,
  output logic [M_W-1:0]             M_control,
  output logic [W_W-1:0]             W_control,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  import decode_out_queue_pkg::*;

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int BUNDLE_W = bundle_width(IR_W, NPC_W, E_W, M_W, W_W);
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] cnt_q,    cnt_d;

  logic                push, pop;
  logic [DEPTH-1:0]    wr_en;
  logic [BUNDLE_W-1:0] wr_data, rd_data;

  // Ready looks only at registered occupancy, so a pop never refills in the same cycle.
  assign in_ready      = (cnt_q < FULL_CNT) && !reset;
  assign enable_decode = in_ready;
  assign out_valid     = (cnt_q != '0);
  assign count         = cnt_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
      cnt_d = cnt_q + CNT_BITS'(push) - CNT_BITS'(pop);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wr_en   = (push && !flush) ? (DEPTH'(1) << wr_ptr_q) : '0;
  assign wr_data = {IR_in, npc_in, E_control_in, M_control_in, W_control_in};

  decode_out_entry_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BUNDLE_W)
  ) u_entry_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Payload is zero whenever the head is not valid.
  assign {IR, npc_out, E_control, M_control, W_control} = out_valid ? rd_data : '0;

endmodule

// File: tb/tb_decode_out_queue.sv
// Scoreboard bench driving a DEPTH=2 and a DEPTH=4 queue with identical stimulus;
// each has its own expected-bundle queue pushed on accept and popped on consume.
module tb_decode_out_queue;
  import decode_out_queue_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic           rst = 1'b1;
  logic           fl = 1'b0;
  logic           iv = 1'b0;
  logic           ordy = 1'b0;
  decode_bundle_t bin = '0;

  decode_out_queue_if #(.DEPTH(2)) if2 ();
  decode_out_queue_if #(.DEPTH(4)) if4 ();

  assign if2.flush = fl;  assign if2.in_valid = iv;  assign if2.out_ready = ordy;
  assign if4.flush = fl;  assign if4.in_valid = iv;  assign if4.out_ready = ordy;
  assign {if2.IR_in, if2.npc_in, if2.E_control_in, if2.M_control_in, if2.W_control_in} = bin;
  assign {if4.IR_in, if4.npc_in, if4.E_control_in, if4.M_control_in, if4.W_control_in} = bin;

  decode_out_queue #(.DEPTH(2)) dut2 (
    .clock(clock), .reset(rst), .flush(if2.flush), .in_valid(if2.in_valid),
    .in_ready(if2.in_ready), .enable_decode(if2.enable_decode),
    .IR_in(if2.IR_in), .npc_in(if2.npc_in), .E_control_in(if2.E_control_in),
    .M_control_in(if2.M_control_in), .W_control_in(if2.W_control_in),
    .out_valid(if2.out_valid), .out_ready(if2.out_ready),
    .IR(if2.IR), .npc_out(if2.npc_out), .E_control(if2.E_control),
    .M_control(if2.M_control), .W_control(if2.W_control), .count(if2.count)
  );

  decode_out_queue #(.DEPTH(4)) dut4 (
    .clock(clock), .reset(rst), .flush(if4.flush), .in_valid(if4.in_valid),
    .in_ready(if4.in_ready), .enable_decode(if4.enable_decode),
    .IR_in(if4.IR_in), .npc_in(if4.npc_in), .E_control_in(if4.E_control_in),
    .M_control_in(if4.M_control_in), .W_control_in(if4.W_control_in),
    .out_valid(if4.out_valid), .out_ready(if4.out_ready),
    .IR(if4.IR), .npc_out(if4.npc_out), .E_control(if4.E_control),
    .M_control(if4.M_control), .W_control(if4.W_control), .count(if4.count)
  );

  decode_bundle_t obs_b   [2];
  logic           obs_v   [2];
  logic           obs_rdy [2];
  logic           obs_en  [2];
  logic [2:0]     obs_cnt [2];

  assign obs_b[0]   = {if2.IR, if2.npc_out, if2.E_control, if2.M_control, if2.W_control};
  assign obs_b[1]   = {if4.IR, if4.npc_out, if4.E_control, if4.M_control, if4.W_control};
  assign obs_v[0]   = if2.out_valid;       assign obs_v[1]   = if4.out_valid;
  assign obs_rdy[0] = if2.in_ready;        assign obs_rdy[1] = if4.in_ready;
  assign obs_en[0]  = if2.enable_decode;   assign obs_en[1]  = if4.enable_decode;
  assign obs_cnt[0] = {1'b0, if2.count};   assign obs_cnt[1] = if4.count;

  decode_bundle_t sb [2][$];
  int             sb_depth [2] = '{2, 4};
  string          inst_name [2] = '{"d2", "d4"};

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      decode_bundle_t head;
      int             sz;
      sz   = sb[k].size();
      head = (sz > 0) ? sb[k][0] : '0;
      check({tag, "/", inst_name[k], "/out_valid"}, 64'(obs_v[k]), 64'(sz > 0));
      check({tag, "/", inst_name[k], "/count"}, 64'(obs_cnt[k]), 64'(sz));
      check({tag, "/", inst_name[k], "/in_ready"}, 64'(obs_rdy[k]), 64'(!rst && sz < sb_depth[k]));
      check({tag, "/", inst_name[k], "/enable_decode"}, 64'(obs_en[k]), 64'(!rst && sz < sb_depth[k]));
      check({tag, "/", inst_name[k], "/payload"}, 64'(obs_b[k]), 64'(head));
    end
  endtask

  // One clock: drive inputs, check outputs before the edge, then advance the scoreboards.
  task automatic step(input string tag, input logic r, input logic f, input logic v,
                      input logic o, input decode_bundle_t b);
    rst = r; fl = f; iv = v; ordy = o; bin = b;
    #1;
    check_all(tag);
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      int sz;
      sz = sb[k].size();
      if (r || f) begin
        sb[k].delete();
      end else begin
        if (o && sz > 0) void'(sb[k].pop_front());
        if (v && sz < sb_depth[k]) sb[k].push_back(b);
      end
    end
    #1;
  endtask

  function automatic decode_bundle_t mk(input logic [15:0] ir, input logic [15:0] npc);
    decode_bundle_t b;
    b.ir        = ir;
    b.npc       = npc;
    b.e_control = 6'($urandom);
    b.m_control = 1'($urandom);
    b.w_control = 2'($urandom);
    return b;
  endfunction

  initial begin
    decode_bundle_t beef;
    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Reset release and idle.
    step("idle0", 0, 0, 0, 0, '0);
    step("idle1", 0, 0, 0, 0, '0);

    // Single push with execute stalled.
    step("push1", 0, 0, 1, 0, mk(16'h1234, 16'h3001));
    step("hold1", 0, 0, 0, 0, '0);
    step("drain1", 0, 0, 0, 1, '0);
    step("empty1", 0, 0, 0, 1, '0);

    // Three back-to-back pushes with execute stalled; DEPTH=2 refuses the third.
    step("fill_a", 0, 0, 1, 0, mk(16'hA001, 16'h3010));
    step("fill_b", 0, 0, 1, 0, mk(16'hA002, 16'h3011));
    step("fill_c", 0, 0, 1, 0, mk(16'hA003, 16'h3012));
    step("full",   0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) step($sformatf("drain_%0d", i), 0, 0, 0, 1, '0);

    // Streaming with execute always ready: occupancy stays at one, pointers wrap.
    for (int i = 0; i < 10; i++)
      step($sformatf("stream_%0d", i), 0, 0, 1, 1, mk(16'h5000 + 16'(i), 16'h4000 + 16'(i)));
    step("stream_tail", 0, 0, 0, 1, '0);
    step("stream_done", 0, 0, 0, 1, '0);

    // Fill both queues, then flush while a bundle is offered.
    for (int i = 0; i < 4; i++)
      step($sformatf("pref_%0d", i), 0, 0, 1, 0, mk(16'hC000 + 16'(i), 16'h6000 + 16'(i)));
    beef = mk(16'hBEEF, 16'h7777);
    step("flush", 0, 1, 1, 0, beef);
    step("post_flush0", 0, 0, 0, 1, '0);
    check("flush_no_beef/d2", 64'(if2.IR == 16'hBEEF), 64'd0);
    check("flush_no_beef/d4", 64'(if4.IR == 16'hBEEF), 64'd0);
    step("post_flush1", 0, 0, 0, 1, '0);

    // Reset with two entries held and a push in progress, then a fresh push.
    step("rpre_0", 0, 0, 1, 0, mk(16'hD000, 16'h8000));
    step("rpre_1", 0, 0, 1, 0, mk(16'hD001, 16'h8001));
    step("reset_mid", 1, 0, 1, 0, mk(16'hD002, 16'h8002));
    step("post_reset", 0, 0, 0, 0, '0);
    step("fresh_push", 0, 0, 1, 0, mk(16'h0F0F, 16'h3100));
    step("fresh_seen", 0, 0, 0, 1, '0);
    step("final_idle", 0, 0, 0, 1, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
